// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Turns a command byte stream from the UART receive path into 32-bit
//   reads and writes on a picorv32-style native memory bus (mem_valid /
//   mem_ready). It sends the response bytes back on the UART transmit path.
//
//   Commands (multi-byte fields little-endian):
//     'R' a0 a1 a2 a3           -> read,  reply d0 d1 d2 d3 (LSB first)
//     'W' a0 a1 a2 a3 d0..d3    -> write, reply 'K'
//     unknown opcode            -> reply '?'
//     bus access timed out      -> reply 'T'
//
//   Optional feature macro: UART_BUS_BRIDGE_AUTOINC_EN
//     When this macro is defined, mem_addr advances by 4 after each
//     completed access. It also adds two opcodes:
//       'n' reads at the current address.
//       'm' d0..d3 writes at the current address.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rx_data/valid/ready  command byte input (valid/ready handshake)
//   tx_data/valid/ready  response byte output (valid/ready handshake)
//   mem_valid/ready      bus request / completion
//   mem_addr/wdata/wstrb request fields, held stable while mem_valid is high
//   mem_rdata            read data, sampled in the mem_ready cycle
//   busy                 high whenever the bridge is not idle
module uart_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t            state_r;
  logic              is_write_r;
  logic [1:0]        byte_cnt_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic [23:0]       resp_r;       // read bytes still waiting behind tx_data
  logic [1:0]        resp_left_r;  // bytes left to send after the current one

  // Command parser, bus initiator and response sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      is_write_r  <= 1'b0;
      byte_cnt_r  <= 2'd0;
      to_cnt_r    <= '0;
      resp_r      <= 24'd0;
      resp_left_r <= 2'd0;
      rx_ready    <= 1'b0;
      tx_data     <= 8'd0;
      tx_valid    <= 1'b0;
      mem_valid   <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_wstrb   <= 4'b0000;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // rx_ready comes up one cycle after reset is released
          rx_ready <= 1'b1;
          if (rx_valid && rx_ready) begin
            case (rx_data)
              8'h52: begin
                is_write_r <= 1'b0;
                byte_cnt_r <= 2'd0;
                busy       <= 1'b1;
                state_r    <= ADDR;
              end
              8'h57: begin
                is_write_r <= 1'b1;
                byte_cnt_r <= 2'd0;
                busy       <= 1'b1;
                state_r    <= ADDR;
              end
`ifdef UART_BUS_BRIDGE_AUTOINC_EN
              8'h6E: begin
                // read at the current address, no address bytes follow
                is_write_r <= 1'b0;
                rx_ready   <= 1'b0;
                mem_valid  <= 1'b1;
                mem_wstrb  <= 4'b0000;
                to_cnt_r   <= '0;
                busy       <= 1'b1;
                state_r    <= BUS;
              end
              8'h6D: begin
                is_write_r <= 1'b1;
                byte_cnt_r <= 2'd0;
                busy       <= 1'b1;
                state_r    <= DATA;
              end
`endif
              default: begin
                rx_ready    <= 1'b0;
                tx_valid    <= 1'b1;
                tx_data     <= 8'h3F;
                resp_left_r <= 2'd0;
                busy        <= 1'b1;
                state_r     <= RESP;
              end
            endcase
          end
        end

        ADDR: begin
          if (rx_valid && rx_ready) begin
            // the low two address bits are never allowed onto the bus
            case (byte_cnt_r)
              2'd0:    mem_addr[7:0]   <= {rx_data[7:2], 2'b00};
              2'd1:    mem_addr[15:8]  <= rx_data;
              2'd2:    mem_addr[23:16] <= rx_data;
              2'd3:    mem_addr[31:24] <= rx_data;
              default: mem_addr        <= mem_addr;
            endcase
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              if (is_write_r) begin
                state_r <= DATA;
              end else begin
                rx_ready  <= 1'b0;
                mem_valid <= 1'b1;
                mem_wstrb <= 4'b0000;
                to_cnt_r  <= '0;
                state_r   <= BUS;
              end
            end
          end
        end

        DATA: begin
          if (rx_valid && rx_ready) begin
            // shift in from the top so the first byte lands in [7:0]
            mem_wdata  <= {rx_data, mem_wdata[31:8]};
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              rx_ready  <= 1'b0;
              mem_valid <= 1'b1;
              mem_wstrb <= 4'b1111;
              to_cnt_r  <= '0;
              state_r   <= BUS;
            end
          end
        end

        BUS: begin
          // completion takes priority over a timeout on the same edge
          if (mem_ready) begin
            mem_valid <= 1'b0;
            tx_valid  <= 1'b1;
            state_r   <= RESP;
            if (is_write_r) begin
              tx_data     <= 8'h4B;
              resp_left_r <= 2'd0;
            end else begin
              tx_data     <= mem_rdata[7:0];
              resp_r      <= mem_rdata[31:8];
              resp_left_r <= 2'd3;
            end
`ifdef UART_BUS_BRIDGE_AUTOINC_EN
            mem_addr <= mem_addr + 32'd4;
`endif
          end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
            mem_valid   <= 1'b0;
            tx_valid    <= 1'b1;
            tx_data     <= 8'h54;
            resp_left_r <= 2'd0;
            state_r     <= RESP;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
          end
        end

        RESP: begin
          if (tx_valid && tx_ready) begin
            if (resp_left_r == 2'd0) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              busy     <= 1'b0;
              state_r  <= IDLE;
            end else begin
              tx_data     <= resp_r[7:0];
              resp_r      <= {8'h00, resp_r[23:8]};
              resp_left_r <= resp_left_r - 2'd1;
            end
          end
        end

        default: begin
          rx_ready  <= 1'b0;
          tx_valid  <= 1'b0;
          mem_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Byte-stream-to-bus initiator used for recovery loading and debug over the serial link.
- Parses command bytes from the UART receive path and issues 32-bit reads and writes as an initiator on the picorv32-style native memory interface (mem_valid/mem_ready).
- Returns response bytes to the UART transmit path.
- Sits beside the core; an external arbiter merges its bus port with the core's.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles mem_valid may stay high without mem_ready before the access is abandoned.
- TO_W, 11: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  bridge accepts a byte; transfer occurs when rx_valid && rx_ready at posedge.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts a byte; transfer occurs when tx_valid && tx_ready at posedge.
- mem_valid  out  1  bus request.
- mem_ready  in  1  bus completion.
- mem_addr  out  32  byte address; bits [1:0] always 0.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b1111 for writes, 4'b0000 for reads.
- mem_rdata  in  32  read data; valid in the cycle mem_ready is high.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, state=IDLE, all counters 0.
  - Reset asserted mid-command or mid-access: partial bytes are discarded and mem_valid drops at that same edge. No response is sent.
- Command formats (all multi-byte fields little-endian):
  - 'R' (0x52) + 4 address bytes: 32-bit read. Response is 4 data bytes, LSB first.
  - 'W' (0x57) + 4 address bytes + 4 data bytes: 32-bit write. Response is 'K' (0x4B).
  - Any other opcode: response '?' (0x3F), then return to IDLE.
  - Bus timeout: response 'T' (0x54) instead of data or 'K'.
- State machine: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: rx_ready=1. On accepted byte, latch opcode.
    - Valid opcode -> ADDR, byte count=0.
    - Invalid opcode -> RESP with '?'.
  - ADDR: rx_ready=1. Shift accepted bytes into mem_addr[8*i +: 8].
    - After the 4th byte: 'W' -> DATA; 'R' -> BUS.
    - mem_addr[1:0] is forced to 0 on entry to BUS.
  - DATA: rx_ready=1. Collect 4 bytes into mem_wdata, then -> BUS.
  - BUS: rx_ready=0. mem_valid=1 from the first BUS cycle. mem_addr, mem_wdata and mem_wstrb are stable while mem_valid is high.
    - Edge where mem_ready=1: capture mem_rdata into the response register, drop mem_valid on that edge, go to RESP.
    - Timeout counter starts at 0 and increments each BUS cycle with mem_ready=0. When it reaches TIMEOUT_CYCLES-1: drop mem_valid, respond 'T', go to RESP.
    - mem_ready and timeout expiring on the same edge: mem_ready wins.
  - RESP: rx_ready=0. tx_valid=1 with tx_data stable until accepted.
    - Byte count: 4 for a read, 1 otherwise.
    - After the last accepted byte: tx_valid=0 -> IDLE.
    - tx_ready held low: remain in RESP indefinitely; no timeout applies.
- rx_valid while rx_ready=0: the byte is not consumed. Upstream holds it.
- Latency, assuming rx_valid, tx_ready and a zero-wait responder:
  - Last command byte accepted at edge N -> mem_valid high after edge N.
  - mem_ready seen at edge M -> tx_valid high after edge M.
- mem_ready while mem_valid=0: ignored.

Optional Feature:
- Macro: UART_BUS_BRIDGE_AUTOINC_EN.
- Defined:
  - After every successfully completed access (not on timeout), mem_addr increments by 4, wrapping 0xFFFFFFFC -> 0x00000000.
  - Opcode 'n' (0x6E): read at the current mem_addr with no address bytes (IDLE -> BUS).
  - Opcode 'm' (0x6D) + 4 data bytes: write at the current mem_addr (IDLE -> DATA).
  - mem_addr is not cleared between commands.
- Not defined:
  - mem_addr is unchanged after an access.
  - 'n' and 'm' are unknown opcodes and respond '?'.

Test Plan:
- 'W',00,01,00,00,EF,BE,AD,DE; responder ready after 2 cycles -> one request with mem_addr=0x00000100, mem_wdata=0xDEADBEEF, mem_wstrb=4'b1111; tx emits 0x4B.
- 'R',00,01,00,00; responder returns 0x12345678 -> mem_wstrb=0; tx emits 78,56,34,12 in that order; busy falls after the last byte.
- 'R',03,00,00,01 -> mem_addr=0x01000000 (low bits forced to 0).
- 'R' to an address that never gets mem_ready, TIMEOUT_CYCLES=16 -> mem_valid high for exactly 16 cycles, then 0; tx emits 0x54; a following 'W' command completes normally.
- 0x00 opcode -> tx emits 0x3F. Also: tx_ready held low for 50 cycles during the read response -> tx_data stable, no byte lost or repeated, rx_ready=0 throughout.
- rst pulsed after 2 address bytes -> next cycle mem_valid=0, tx_valid=0, busy=0; a fresh 'R' command then works. With AUTOINC_EN: 'R' to 0xFFFFFFFC then 'n' -> second access at 0x00000000.
